// File: rtl/acc_offload_arbiter_pkg.sv
// Shared definitions for the accelerator offload arbiter.
//
// Contents:
//   AccMaxOutstanding - default per-requester limit on in-flight offloads
//   acc_req_chan_t    - default request payload type
//   acc_rsp_chan_t    - default response payload type
//   idx_width()       - index width needed to address n requesters (min 1)
package acc_offload_arbiter_pkg;

  localparam int unsigned AccMaxOutstanding = 4;

  typedef logic acc_req_chan_t;
  typedef logic acc_rsp_chan_t;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 1) ? $clog2(num_idx) : 1;
  endfunction

endpackage

// File: rtl/acc_outstanding_cnt.sv
// Up/down saturating counter tracking in-flight offloads of one requester.
//
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   inc_i        - a request from this requester was accepted
//   dec_i        - a response to this requester completed its handshake
//   full_o       - count has reached MaxCount (requester must be throttled)
//   empty_o      - count is zero
module acc_outstanding_cnt #(
  parameter int unsigned MaxCount = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned CntWidth = $clog2(MaxCount + 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                inc_eff, dec_eff;

  assign full_o  = (cnt_q == CntWidth'(MaxCount));
  assign empty_o = (cnt_q == '0);

  // Saturate at both ends; a decrement at zero is dropped before it can
  // cancel a simultaneous increment.
  assign inc_eff = inc_i && !full_o;
  assign dec_eff = dec_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_eff && !dec_eff) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_eff && !inc_eff) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acc_offload_arbiter.sv
// Shares one accelerator port between NumReq offloading cores.
// Requests are arbitrated round-robin and registered into a single output
// slot tagged with the requester index; responses are routed back
// combinationally by their tag. Each requester is throttled once it has
// MaxOutstanding offloads in flight.
//
// Ports:
//   clk_i, rst_i           - clock, asynchronous active-high reset
//   mst_q_i/_valid_i/_ready_o - per-core request channel
//   mst_p_o/_valid_o/_ready_i - per-core response channel (payload broadcast)
//   slv_q_o/_id_o/_valid_o/_ready_i - registered request to accelerator
//   slv_p_i/_id_i/_valid_i/_ready_o - response from accelerator
//   busy_o                 - any offload in flight or output slot occupied
//   err_o                  - sticky spurious-response flag
//
// Build option: define ACC_OFFLOAD_ARB_ERR_CHECK_EN to drop and flag
// responses whose destination has nothing outstanding. Without it such
// responses are forwarded and err_o is tied low. Out-of-range ids are
// always absorbed (ready high, not forwarded) so the accelerator never stalls.
module acc_offload_arbiter
  import acc_offload_arbiter_pkg::*;
#(
  parameter  int unsigned NumReq         = 2,
  parameter  int unsigned MaxOutstanding = AccMaxOutstanding,
  parameter  type         req_chan_t     = acc_req_chan_t,
  parameter  type         rsp_chan_t     = acc_rsp_chan_t,
  localparam int unsigned IdWidth        = idx_width(NumReq)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  req_chan_t          mst_q_i [NumReq],
  input  logic [NumReq-1:0]  mst_q_valid_i,
  output logic [NumReq-1:0]  mst_q_ready_o,
  output rsp_chan_t          mst_p_o,
  output logic [NumReq-1:0]  mst_p_valid_o,
  input  logic [NumReq-1:0]  mst_p_ready_i,
  output req_chan_t          slv_q_o,
  output logic [IdWidth-1:0] slv_q_id_o,
  output logic               slv_q_valid_o,
  input  logic               slv_q_ready_i,
  input  rsp_chan_t          slv_p_i,
  input  logic [IdWidth-1:0] slv_p_id_i,
  input  logic               slv_p_valid_i,
  output logic               slv_p_ready_o,
  output logic               busy_o,
  output logic               err_o
);

  logic [NumReq-1:0]  full, empty, eligible, inc, dec, rsp_hit;
  logic [IdWidth-1:0] rr_q, rr_d, win_idx;
  logic               win_found, slot_free, req_hs;
  logic               rsp_spurious, rsp_fwd_ready;
  req_chan_t          win_q;

  req_chan_t          slv_q_q;
  logic [IdWidth-1:0] slv_q_id_q;
  logic               slv_q_valid_q;

  assign eligible  = mst_q_valid_i & ~full;
  assign slot_free = !slv_q_valid_q || slv_q_ready_i;

  // Two passes give "first eligible at or after rr_q, wrapping" without a
  // dynamic modulo: indices >= rr_q first, then the wrapped-around ones.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_q     = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (!win_found && eligible[i] && (IdWidth'(i) >= rr_q)) begin
        win_found = 1'b1;
        win_idx   = IdWidth'(i);
        win_q     = mst_q_i[i];
      end
    end
    for (int i = 0; i < int'(NumReq); i++) begin
      if (!win_found && eligible[i]) begin
        win_found = 1'b1;
        win_idx   = IdWidth'(i);
        win_q     = mst_q_i[i];
      end
    end
  end

  assign req_hs = win_found && slot_free;

  always_comb begin
    mst_q_ready_o = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      mst_q_ready_o[i] = req_hs && (win_idx == IdWidth'(i));
    end
  end

  assign inc = mst_q_ready_o & mst_q_valid_i;

  always_comb begin
    rr_d = rr_q;
    if (req_hs) begin
      rr_d = (win_idx == IdWidth'(NumReq - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_comb begin
    rsp_hit = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      rsp_hit[i] = (slv_p_id_i == IdWidth'(i));
    end
  end

`ifdef ACC_OFFLOAD_ARB_ERR_CHECK_EN
  assign rsp_spurious = !(|rsp_hit) || (|(rsp_hit & empty));
`else
  assign rsp_spurious = !(|rsp_hit);
`endif

  assign rsp_fwd_ready = |(rsp_hit & mst_p_ready_i);
  assign slv_p_ready_o = rsp_spurious ? 1'b1 : rsp_fwd_ready;
  assign mst_p_valid_o = (slv_p_valid_i && !rsp_spurious) ? rsp_hit : '0;
  assign mst_p_o       = slv_p_i;
  assign dec           = mst_p_valid_o & mst_p_ready_i;

  for (genvar g = 0; g < int'(NumReq); g++) begin : gen_cnt
    acc_outstanding_cnt #(
      .MaxCount (MaxOutstanding)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (inc[g]),
      .dec_i   (dec[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slv_q_q       <= '0;
      slv_q_id_q    <= '0;
      slv_q_valid_q <= 1'b0;
      rr_q          <= '0;
    end else begin
      rr_q <= rr_d;
      if (req_hs) begin
        slv_q_q       <= win_q;
        slv_q_id_q    <= win_idx;
        slv_q_valid_q <= 1'b1;
      end else if (slv_q_ready_i) begin
        slv_q_valid_q <= 1'b0;
      end
    end
  end

  assign slv_q_o       = slv_q_q;
  assign slv_q_id_o    = slv_q_id_q;
  assign slv_q_valid_o = slv_q_valid_q;
  assign busy_o        = slv_q_valid_q || !(&empty);

`ifdef ACC_OFFLOAD_ARB_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (slv_p_valid_i && rsp_spurious) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_acc_offload_arbiter.sv
module tb_acc_offload_arbiter;

  localparam int N   = 3;
  localparam int MAX = 2;
`ifdef ACC_OFFLOAD_ARB_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef logic [7:0] pay_t;

  logic         clk = 1'b0;
  logic         rst;
  pay_t         mst_q [N];
  logic [N-1:0] q_valid, q_ready, p_valid, p_ready;
  pay_t         p_out, sq, sp;
  logic [1:0]   sq_id, sp_id;
  logic         sq_valid, sq_ready, sp_valid, sp_ready, busy, err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acc_offload_arbiter #(
    .NumReq         (N),
    .MaxOutstanding (MAX),
    .req_chan_t     (pay_t),
    .rsp_chan_t     (pay_t)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mst_q_i       (mst_q),
    .mst_q_valid_i (q_valid),
    .mst_q_ready_o (q_ready),
    .mst_p_o       (p_out),
    .mst_p_valid_o (p_valid),
    .mst_p_ready_i (p_ready),
    .slv_q_o       (sq),
    .slv_q_id_o    (sq_id),
    .slv_q_valid_o (sq_valid),
    .slv_q_ready_i (sq_ready),
    .slv_p_i       (sp),
    .slv_p_id_i    (sp_id),
    .slv_p_valid_i (sp_valid),
    .slv_p_ready_o (sp_ready),
    .busy_o        (busy),
    .err_o         (err)
  );

  // Reference model: plain counts, pointer and slot contents.
  int       m_cnt [N];
  int       m_rr, m_sid;
  bit       m_sv, m_err;
  pay_t     m_sd;
  logic [N-1:0] e_qready, e_pvalid;
  logic     e_pready, e_busy;
  int       e_win;
  bit       e_spur;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_rr = 0; m_sid = 0; m_sv = 0; m_err = 0; m_sd = '0;
  endfunction

  function automatic void model_eval();
    int id;
    bit free;
    e_win = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (e_win < 0 && q_valid[c] && m_cnt[c] < MAX) e_win = c;
    end
    free = !m_sv || sq_ready;
    e_qready = '0;
    if (e_win >= 0 && free) e_qready[e_win] = 1'b1;
    id = int'(sp_id);
    if (id >= N) e_spur = 1;
    else e_spur = ERR_EN && (m_cnt[id] == 0);
    e_pvalid = '0;
    if (sp_valid && !e_spur) e_pvalid[id] = 1'b1;
    e_pready = e_spur ? 1'b1 : p_ready[id];
    e_busy = m_sv;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) e_busy = 1'b1;
  endfunction

  function automatic void model_commit();
    int  id;
    bit  hs, dec_ok;
    id = int'(sp_id);
    hs = (e_win >= 0) && e_qready[e_win];
    dec_ok = (e_pvalid != '0) && p_ready[id] && (m_cnt[id] > 0);
    if (hs) m_cnt[e_win]++;
    if (dec_ok) m_cnt[id]--;
    if (hs) begin
      m_sv = 1; m_sd = mst_q[e_win]; m_sid = e_win; m_rr = (e_win + 1) % N;
    end else if (sq_ready) begin
      m_sv = 0;
    end
    if (ERR_EN && sp_valid && e_spur) m_err = 1;
  endfunction

  task automatic idle();
    q_valid = '0; sq_ready = 1'b1; sp_valid = 1'b0; sp_id = '0;
    sp = pay_t'($urandom); p_ready = '1;
    for (int i = 0; i < N; i++) mst_q[i] = pay_t'($urandom);
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 40; t++) begin
      int pick;
      idle();
      pick = -1;
      for (int i = 0; i < N; i++) if (pick < 0 && m_cnt[i] > 0) pick = i;
      if (pick < 0 && !m_sv) break;
      if (pick >= 0) begin sp_valid = 1'b1; sp_id = 2'(pick); end
      settle();
      advance();
    end
    idle();
    settle();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL drain_busy: got %b expected 0", busy); end
    advance();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    q_valid = '1;
    @(negedge clk);
    model_reset();
    model_eval();
    checks++; if (sq_valid !== 1'b0) begin failures++; $display("FAIL reset_sq_valid: got %b expected 0", sq_valid); end
    checks++; if (sq !== 8'h00 || sq_id !== 2'd0) begin failures++; $display("FAIL reset_slot: got %h/%0d expected 00/0", sq, sq_id); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_flags: got busy=%b err=%b expected 0/0", busy, err); end
    checks++; if (q_ready !== 3'b001) begin failures++; $display("FAIL reset_qready: got %b expected 001", q_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
  endtask

  task automatic test_round_robin();
    for (int k = 0; k <= 6; k++) begin
      idle();
      q_valid = '1;
      settle();
      if (k >= 1) begin
        checks++;
        if (sq_valid !== 1'b1 || int'(sq_id) != (k - 1) % N) begin
          failures++; $display("FAIL rr_id[%0d]: got v=%b id=%0d expected v=1 id=%0d", k, sq_valid, sq_id, (k - 1) % N);
        end
        checks++; if (sq !== m_sd) begin failures++; $display("FAIL rr_payload[%0d]: got %h expected %h", k, sq, m_sd); end
      end
      checks++;
      if (k == 6) begin
        if (q_ready !== 3'b000) begin failures++; $display("FAIL rr_all_full: got %b expected 000", q_ready); end
      end else if (q_ready !== e_qready) begin
        failures++; $display("FAIL rr_qready[%0d]: got %b expected %b", k, q_ready, e_qready);
      end
      advance();
    end
    drain();
  endtask

  task automatic test_limit();
    logic [4:0] exp_rdy;
    exp_rdy = 5'b10011;
    for (int k = 0; k < 5; k++) begin
      idle();
      q_valid = 3'b010;
      if (k == 3) begin sp_valid = 1'b1; sp_id = 2'd1; end
      settle();
      checks++;
      if (q_ready[1] !== exp_rdy[k]) begin failures++; $display("FAIL limit_ready1[%0d]: got %b expected %b", k, q_ready[1], exp_rdy[k]); end
      if (k == 3) begin
        checks++; if (p_valid !== 3'b010) begin failures++; $display("FAIL limit_pvalid: got %b expected 010", p_valid); end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_backpressure();
    idle();
    q_valid = '1;
    sq_ready = 1'b0;
    settle();
    advance();
    for (int k = 0; k < 5; k++) begin
      idle();
      q_valid = '1;
      sq_ready = 1'b0;
      settle();
      checks++;
      if (sq_valid !== 1'b1 || sq !== m_sd || int'(sq_id) != m_sid) begin
        failures++; $display("FAIL bp_hold[%0d]: got v=%b %h/%0d expected v=1 %h/%0d", k, sq_valid, sq, sq_id, m_sd, m_sid);
      end
      checks++; if (q_ready !== 3'b000) begin failures++; $display("FAIL bp_qready[%0d]: got %b expected 000", k, q_ready); end
      advance();
    end
    drain();
  endtask

  task automatic test_rsp_ready();
    idle();
    q_valid = 3'b100;
    settle();
    advance();
    for (int k = 0; k < 4; k++) begin
      idle();
      sp_valid = 1'b1;
      sp_id = 2'd2;
      p_ready = (k < 3) ? 3'b011 : 3'b111;
      settle();
      checks++;
      if (sp_ready !== (k == 3)) begin failures++; $display("FAIL rspr_ready[%0d]: got %b expected %b", k, sp_ready, (k == 3)); end
      checks++; if (p_valid !== 3'b100) begin failures++; $display("FAIL rspr_pvalid[%0d]: got %b expected 100", k, p_valid); end
      if (k < 3) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rspr_busy[%0d]: got %b expected 1", k, busy); end
      end
      advance();
    end
    idle();
    settle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rspr_done: got busy=%b expected 0", busy); end
    advance();
  endtask

  task automatic test_same_cycle();
    idle();
    q_valid = 3'b001;
    settle();
    advance();
    idle();
    q_valid = 3'b001;
    sp_valid = 1'b1;
    sp_id = 2'd0;
    settle();
    checks++; if (q_ready !== 3'b001 || sp_ready !== 1'b1) begin failures++; $display("FAIL same_hs: got qr=%b pr=%b expected 001/1", q_ready, sp_ready); end
    advance();
    idle();
    q_valid = 3'b001;
    settle();
    checks++; if (q_ready[0] !== 1'b1) begin failures++; $display("FAIL same_second: got %b expected 1", q_ready[0]); end
    advance();
    idle();
    q_valid = 3'b001;
    settle();
    checks++; if (q_ready[0] !== 1'b0) begin failures++; $display("FAIL same_limit: got %b expected 0", q_ready[0]); end
    advance();
    drain();
  endtask

  task automatic test_spurious();
    logic [2:0] exp_rdy;
    exp_rdy = 3'b011;
    idle();
    sp_valid = 1'b1;
    sp_id = 2'd1;
    settle();
    checks++;
    if (p_valid !== (ERR_EN ? 3'b000 : 3'b010) || sp_ready !== 1'b1 || err !== 1'b0) begin
      failures++; $display("FAIL spur_rsp: got pv=%b pr=%b err=%b expected pv=%b pr=1 err=0", p_valid, sp_ready, err, ERR_EN ? 3'b000 : 3'b010);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      idle();
      q_valid = 3'b010;
      settle();
      checks++; if (err !== ERR_EN) begin failures++; $display("FAIL spur_err[%0d]: got %b expected %b", k, err, ERR_EN); end
      checks++; if (q_ready[1] !== exp_rdy[k]) begin failures++; $display("FAIL spur_cnt[%0d]: got %b expected %b", k, q_ready[1], exp_rdy[k]); end
      advance();
    end
    idle();
    sp_valid = 1'b1;
    sp_id = 2'd3;
    p_ready = '0;
    settle();
    checks++; if (p_valid !== 3'b000 || sp_ready !== 1'b1) begin failures++; $display("FAIL spur_range: got pv=%b pr=%b expected 000/1", p_valid, sp_ready); end
    advance();
    idle();
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL spur_reset: got err=%b busy=%b expected 0/0", err, busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      idle();
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        checks++;
        if (sq_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
          failures++; $display("FAIL rnd_reset[%0d]: got v=%b busy=%b err=%b expected 0/0/0", t, sq_valid, busy, err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        continue;
      end
      q_valid = 3'($urandom);
      sq_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) p_ready[i] = ($urandom_range(0, 3) != 0);
      sp_valid = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) begin
        sp_id = 2'($urandom_range(0, 3));
      end else begin
        int start, pick;
        start = $urandom_range(0, N - 1);
        pick = $urandom_range(0, N - 1);
        for (int k = N - 1; k >= 0; k--) if (m_cnt[(start + k) % N] > 0) pick = (start + k) % N;
        sp_id = 2'(pick);
      end
      settle();
      checks++; if (q_ready !== e_qready) begin failures++; $display("FAIL rnd_qready[%0d]: got %b expected %b", t, q_ready, e_qready); end
      checks++; if (sq_valid !== m_sv) begin failures++; $display("FAIL rnd_sqvalid[%0d]: got %b expected %b", t, sq_valid, m_sv); end
      if (m_sv) begin
        checks++;
        if (sq !== m_sd || int'(sq_id) != m_sid) begin failures++; $display("FAIL rnd_slot[%0d]: got %h/%0d expected %h/%0d", t, sq, sq_id, m_sd, m_sid); end
      end
      checks++; if (p_valid !== e_pvalid) begin failures++; $display("FAIL rnd_pvalid[%0d]: got %b expected %b", t, p_valid, e_pvalid); end
      checks++; if (sp_ready !== e_pready) begin failures++; $display("FAIL rnd_pready[%0d]: got %b expected %b", t, sp_ready, e_pready); end
      checks++; if (p_out !== sp) begin failures++; $display("FAIL rnd_pdata[%0d]: got %h expected %h", t, p_out, sp); end
      checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy[%0d]: got %b expected %b", t, busy, e_busy); end
      checks++; if (err !== m_err) begin failures++; $display("FAIL rnd_err[%0d]: got %b expected %b", t, err, m_err); end
      advance();
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #12;
    test_reset();
    test_round_robin();
    test_limit();
    test_backpressure();
    test_rsp_ready();
    test_same_cycle();
    test_spurious();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
